// File: rtl/bcd_display_scan.sv
// bcd_display_scan: scans BCD time/date/weekday values onto a 6-digit
// common-anode 7-segment display (active-low an/seg/dp), one digit per slot.
// In the set modes the field being edited blinks.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank a leading zero hour digit
// on the time page).
module bcd_display_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  clk_mode,
  input  logic [23:0] time_bcd,
  input  logic [23:0] date_bcd,
  input  logic [2:0]  weekday,
  input  logic        ampm,
  input  logic [1:0]  edit_field,
  output logic [5:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_digit;
  logic [FW-1:0] r_frame;
  logic          r_blink;
  logic [1:0]    r_prev_mode;
  logic [1:0]    r_prev_field;
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_presc_tc;
  logic          w_frame_end;
  logic          w_edit_change;
  logic          w_wday_page;
  logic          w_time_page;
  logic [23:0]   w_page_bus;
  logic [3:0]    w_nibble;
  logic [5:0]    w_sel;
  logic          w_blink_on;
  logic [5:0]    w_an_next;
  logic [6:0]    w_seg_next;
  logic          w_dp_next;

  // Active-low 7-segment pattern; non-BCD nibbles show a dash.
  function automatic logic [6:0] f_seg7(input logic [3:0] n);
    case (n)
      4'd0:    f_seg7 = 7'h40;
      4'd1:    f_seg7 = 7'h79;
      4'd2:    f_seg7 = 7'h24;
      4'd3:    f_seg7 = 7'h30;
      4'd4:    f_seg7 = 7'h19;
      4'd5:    f_seg7 = 7'h12;
      4'd6:    f_seg7 = 7'h02;
      4'd7:    f_seg7 = 7'h78;
      4'd8:    f_seg7 = 7'h00;
      4'd9:    f_seg7 = 7'h10;
      default: f_seg7 = 7'h3F;
    endcase
  endfunction

  assign w_presc_tc    = (r_presc == PRESC_LAST);
  assign w_frame_end   = w_presc_tc && (r_digit == 3'd5);
  assign w_edit_change = (clk_mode != r_prev_mode) || (edit_field != r_prev_field);
  assign w_wday_page   = (clk_mode == 2'd3) && (edit_field == 2'd3);
  assign w_time_page   = (clk_mode != 2'd3);
  assign w_page_bus    = w_time_page ? time_bcd : date_bcd;
  assign w_sel         = ~(6'b000001 << r_digit);

  // Pick the nibble for the current digit; digit 0 is the leftmost (MS) nibble.
  always_comb begin
    case (r_digit)
      3'd0:    w_nibble = w_page_bus[23:20];
      3'd1:    w_nibble = w_page_bus[19:16];
      3'd2:    w_nibble = w_page_bus[15:12];
      3'd3:    w_nibble = w_page_bus[11:8];
      3'd4:    w_nibble = w_page_bus[7:4];
      default: w_nibble = w_page_bus[3:0];
    endcase
  end

  // Blank the digit when it belongs to the field under edit during the off phase.
  always_comb begin
    w_blink_on = 1'b0;
    if (r_blink && (clk_mode == 2'd1 || clk_mode == 2'd3)) begin
      if (w_wday_page)
        w_blink_on = (r_digit == 3'd5);
      else if (edit_field != 2'd3)
        w_blink_on = (r_digit[2:1] == edit_field);
    end
  end

  // Next display pattern for the current scan slot.
  always_comb begin
    w_an_next  = 6'h3F;
    w_seg_next = 7'h7F;
    w_dp_next  = 1'b1;
    if (w_wday_page) begin
      if (r_digit == 3'd5) begin
        w_an_next  = w_sel;
        w_seg_next = f_seg7({1'b0, weekday} + 4'd1);
      end
    end else begin
      w_an_next  = w_sel;
      w_seg_next = f_seg7(w_nibble);
      w_dp_next  = ~((r_digit == 3'd1) || (r_digit == 3'd3) ||
                     (w_time_page && (r_digit == 3'd5) && ampm));
`ifdef LEADING_ZERO_BLANK_EN
      if (w_time_page && (r_digit == 3'd0) && (w_nibble == 4'd0))
        w_an_next = 6'h3F;
`endif
    end
    if (w_blink_on)
      w_an_next = 6'h3F;
  end

  // Slot prescaler and digit index; the scan free-runs regardless of inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
      r_digit <= 3'd0;
    end else if (w_presc_tc) begin
      r_presc <= '0;
      r_digit <= (r_digit == 3'd5) ? 3'd0 : r_digit + 3'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Frame counter and blink phase; an edit change restarts them so the field shows at once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_frame      <= '0;
      r_blink      <= 1'b0;
      r_prev_mode  <= 2'd0;
      r_prev_field <= 2'd0;
    end else begin
      r_prev_mode  <= clk_mode;
      r_prev_field <= edit_field;
      if (w_edit_change) begin
        r_frame <= '0;
        r_blink <= 1'b0;
      end else if (w_frame_end) begin
        if (r_frame == FRAME_LAST) begin
          r_frame <= '0;
          r_blink <= ~r_blink;
        end else begin
          r_frame <= r_frame + 1'b1;
        end
      end
    end
  end

  // Registered pin drivers, one cycle behind the digit index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_an  <= 6'h3F;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
      r_dp  <= w_dp_next;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: scoreboard bench. Stimulus pushes expected outputs
// tagged with the cycle they must appear on; a monitor compares at negedge.
// Two instances: A (SCAN_DIV=2, BLINK_DIV=64) and B (SCAN_DIV=1, BLINK_DIV=2).
module tb_bcd_display_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  clk_mode;
  logic [23:0] time_bcd;
  logic [23:0] date_bcd;
  logic [2:0]  weekday;
  logic        ampm;
  logic [1:0]  edit_field;
  logic [5:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    int         which;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    bit         cs;
    bit         cd;
    string      nm;
  } sb_t;

  sb_t sb_q[$];

  always #5 clk = ~clk;

  // Cycle index = number of posedges seen.
  always @(posedge clk) cyc <= cyc + 1;

  bcd_display_scan #(.SCAN_DIV(2), .BLINK_DIV(64)) u_dut_a (
    .clk(clk), .rst(rst), .clk_mode(clk_mode), .time_bcd(time_bcd),
    .date_bcd(date_bcd), .weekday(weekday), .ampm(ampm),
    .edit_field(edit_field), .an(an_a), .seg(seg_a), .dp(dp_a)
  );

  bcd_display_scan #(.SCAN_DIV(1), .BLINK_DIV(2)) u_dut_b (
    .clk(clk), .rst(rst), .clk_mode(clk_mode), .time_bcd(time_bcd),
    .date_bcd(date_bcd), .weekday(weekday), .ampm(ampm),
    .edit_field(edit_field), .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  function automatic logic [5:0] an_of(input int k);
    logic [5:0] m;
    m = 6'b000001 << k;
    return ~m;
  endfunction

  function automatic void push_exp(input int which, input int cy, input logic [5:0] e_an,
                                   input logic [6:0] e_seg, input logic e_dp,
                                   input bit cs, input bit cd, input string nm);
    sb_t e;
    e.cyc = cy; e.which = which; e.an = e_an; e.seg = e_seg; e.dp = e_dp;
    e.cs = cs; e.cd = cd; e.nm = nm;
    sb_q.push_back(e);
  endfunction

  task automatic check_entry(input sb_t e);
    logic [5:0] g_an;
    logic [6:0] g_seg;
    logic       g_dp;
    bit         bad;
    if (e.which == 0) begin g_an = an_a; g_seg = seg_a; g_dp = dp_a; end
    else              begin g_an = an_b; g_seg = seg_b; g_dp = dp_b; end
    bad = (g_an !== e.an) || (e.cs && (g_seg !== e.seg)) || (e.cd && (g_dp !== e.dp));
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s cyc=%0d dut=%s: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
               e.nm, cyc, (e.which == 0) ? "A" : "B", g_an, g_seg, g_dp, e.an, e.seg, e.dp);
    end else begin
      $display("[TB] ok %s cyc=%0d dut=%s an=%b seg=%h dp=%b",
               e.nm, cyc, (e.which == 0) ? "A" : "B", g_an, g_seg, g_dp);
    end
  endtask

  // Monitor: compare every expectation due on this cycle.
  initial begin
    forever begin
      sb_t keep[$];
      @(negedge clk);
      keep = {};
      foreach (sb_q[i]) begin
        if (sb_q[i].cyc == cyc) begin
          check_entry(sb_q[i]);
        end else if (sb_q[i].cyc < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s: expectation for cyc %0d expired at cyc %0d", sb_q[i].nm, sb_q[i].cyc, cyc);
        end else begin
          keep.push_back(sb_q[i]);
        end
      end
      sb_q = keep;
    end
  end

  // Assert reset for two edges, expect reset values, release. base = first
  // cycle whose outputs show digit 0.
  task automatic reset_run(output int base);
    @(negedge clk);
    rst = 1'b0;
    push_exp(0, cyc + 1, 6'h3F, 7'h7F, 1'b1, 1, 1, "reset_a");
    push_exp(1, cyc + 1, 6'h3F, 7'h7F, 1'b1, 1, 1, "reset_b");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    base = cyc + 1;
  endtask

  initial begin
    int b;
    logic [6:0] t_seg [6];
    logic       t_dp  [6];
    t_seg = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
    t_dp  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b0;
    clk_mode = 2'd0; time_bcd = 24'h123456; date_bcd = 24'h311224;
    weekday = 3'd2; ampm = 1'b1; edit_field = 2'd0;
    repeat (2) @(negedge clk);

    // Time page scan, both scan rates
    reset_run(b);
    for (int k = 0; k < 6; k++) begin
      push_exp(0, b + 2*k,     an_of(k), t_seg[k], t_dp[k], 1, 1, $sformatf("time_a_d%0d", k));
      push_exp(0, b + 2*k + 1, an_of(k), t_seg[k], t_dp[k], 0, 0, $sformatf("time_a_hold%0d", k));
      push_exp(1, b + k,       an_of(k), t_seg[k], t_dp[k], 1, 1, $sformatf("time_b_d%0d", k));
    end
    push_exp(0, b + 12, an_of(0), 7'h79, 1'b1, 1, 1, "time_a_wrap");
    push_exp(1, b + 6,  an_of(0), 7'h79, 1'b1, 1, 1, "time_b_wrap");
    repeat (16) @(negedge clk);

    // Blink of minutes field in set-time mode, then edit restart (reset lands mid-frame)
    clk_mode = 2'd1; edit_field = 2'd1;
    reset_run(b);
    push_exp(1, b,      6'b111110, 7'h79, 1'b1, 1, 0, "blink_f0_d0");
    push_exp(1, b + 2,  6'b111011, 7'h30, 1'b1, 1, 0, "blink_f0_d2");
    push_exp(1, b + 3,  6'b110111, 7'h19, 1'b0, 1, 0, "blink_f0_d3");
    push_exp(1, b + 8,  6'b111011, 7'h30, 1'b1, 1, 0, "blink_f1_d2");
    push_exp(1, b + 9,  6'b110111, 7'h19, 1'b0, 1, 0, "blink_f1_d3");
    push_exp(1, b + 12, 6'b111110, 7'h79, 1'b1, 1, 0, "blink_f2_d0");
    push_exp(1, b + 14, 6'h3F,     7'h30, 1'b1, 0, 0, "blink_f2_d2_off");
    push_exp(1, b + 15, 6'h3F,     7'h19, 1'b0, 0, 0, "blink_f2_d3_off");
    push_exp(1, b + 16, 6'b101111, 7'h12, 1'b1, 1, 0, "blink_f2_d4");
    push_exp(1, b + 17, 6'b011111, 7'h02, 1'b0, 1, 1, "blink_f2_d5");
    repeat (19) @(negedge clk);
    edit_field = 2'd0;
    push_exp(1, b + 20, 6'b111011, 7'h30, 1'b1, 1, 0, "restart_f3_d2");
    push_exp(1, b + 21, 6'b110111, 7'h19, 1'b0, 1, 0, "restart_f3_d3");
    push_exp(1, b + 24, 6'b111110, 7'h79, 1'b1, 1, 0, "restart_f4_d0");
    push_exp(1, b + 25, 6'b111101, 7'h24, 1'b0, 1, 0, "restart_f4_d1");
    push_exp(1, b + 30, 6'h3F,     7'h79, 1'b1, 0, 0, "restart_f5_d0_off");
    push_exp(1, b + 31, 6'h3F,     7'h24, 1'b0, 0, 0, "restart_f5_d1_off");
    push_exp(1, b + 32, 6'b111011, 7'h30, 1'b1, 1, 0, "restart_f5_d2");
    repeat (16) @(negedge clk);

    // Weekday page
    clk_mode = 2'd3; edit_field = 2'd3; weekday = 3'd2;
    reset_run(b);
    for (int k = 0; k < 5; k++)
      push_exp(1, b + k, 6'h3F, 7'h7F, 1'b1, 0, 0, $sformatf("wday_dark_d%0d", k));
    push_exp(1, b + 5,  6'b011111, 7'h30, 1'b1, 1, 1, "wday_d5");
    push_exp(1, b + 11, 6'b011111, 7'h30, 1'b1, 1, 1, "wday_f1_d5");
    push_exp(1, b + 17, 6'h3F,     7'h30, 1'b1, 0, 0, "wday_f2_d5_blink");
    repeat (20) @(negedge clk);

    // Date page: no AM/PM point on digit 5
    clk_mode = 2'd3; edit_field = 2'd0; date_bcd = 24'h311224; ampm = 1'b1;
    reset_run(b);
    push_exp(0, b,      6'b111110, 7'h30, 1'b1, 1, 1, "date_a_d0");
    push_exp(0, b + 2,  6'b111101, 7'h79, 1'b0, 1, 1, "date_a_d1");
    push_exp(0, b + 10, 6'b011111, 7'h19, 1'b1, 1, 1, "date_a_d5");
    push_exp(1, b + 2,  6'b111011, 7'h79, 1'b1, 1, 1, "date_b_d2");
    repeat (14) @(negedge clk);

    // Invalid BCD nibble, remaining decode values, AM
    clk_mode = 2'd0; edit_field = 2'd0; time_bcd = 24'hA78000; ampm = 1'b0;
    reset_run(b);
    push_exp(0, b,      6'b111110, 7'h3F, 1'b1, 1, 1, "inv_a_d0_dash");
    push_exp(0, b + 2,  6'b111101, 7'h78, 1'b0, 1, 1, "inv_a_d1_7");
    push_exp(0, b + 4,  6'b111011, 7'h00, 1'b1, 1, 1, "inv_a_d2_8");
    push_exp(0, b + 10, 6'b011111, 7'h40, 1'b1, 1, 1, "inv_a_d5_am");
    push_exp(1, b + 3,  6'b110111, 7'h40, 1'b0, 1, 1, "inv_b_d3");
    repeat (14) @(negedge clk);

    // Leading zero on the time page
    clk_mode = 2'd0; time_bcd = 24'h091500; ampm = 1'b1;
    reset_run(b);
`ifdef LEADING_ZERO_BLANK_EN
    push_exp(0, b, 6'h3F, 7'h40, 1'b1, 0, 0, "lz_a_d0_blank");
`else
    push_exp(0, b, 6'b111110, 7'h40, 1'b1, 1, 1, "lz_a_d0_zero");
`endif
    push_exp(0, b + 2, 6'b111101, 7'h10, 1'b0, 1, 1, "lz_a_d1_9");
    push_exp(1, b + 5, 6'b011111, 7'h40, 1'b0, 1, 1, "lz_b_d5_pm");
    repeat (14) @(negedge clk);

    // Alarm mode shows time without blinking
    clk_mode = 2'd2; edit_field = 2'd1; time_bcd = 24'h123456;
    reset_run(b);
    push_exp(1, b + 14, 6'b111011, 7'h30, 1'b1, 1, 1, "alarm_f2_d2_noblink");
    push_exp(1, b + 15, 6'b110111, 7'h19, 1'b0, 1, 1, "alarm_f2_d3_noblink");
    repeat (20) @(negedge clk);

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Consumer (reader) side of the clock's BCD time/date buses: time hhmmss, date ddmmyy, weekday, AM/PM flag.
- Drives a 6-digit multiplexed common-anode 7-segment display, one digit per scan slot.
- In set modes it blinks the field currently being edited.
- Sits between the clock/date/format blocks and the board display pins.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot; legal range >= 1.
- BLINK_DIV, 64: full scan frames (6 slots) per blink half-period; legal range >= 1.

Ports:
- clk  in  1  system clock (mclk)
- rst  in  1  synchronous, active-low reset
- clk_mode  in  2  0 run, 1 set time, 2 alarm, 3 set date
- time_bcd  in  24  {hh,mm,ss} BCD
- date_bcd  in  24  {dd,mm,yy} BCD
- weekday  in  3  0..6
- ampm  in  1  1 = PM
- edit_field  in  2  field under edit: 0 hh/dd, 1 mm/mm, 2 ss/yy, 3 weekday
- an  out  6  digit enables, active low; an[0] = leftmost digit = bits [23:20]
- seg  out  7  segments, active low; seg[0]=a ... seg[6]=g
- dp  out  1  decimal point, active low

Behaviour:
- Reset (rst=0 at posedge): an=6'h3F, seg=7'h7F, dp=1. Internal state also cleared: prescaler=0, digit index=0, frame count=0, blink phase=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - At terminal count it wraps to 0 and the digit index advances 0->1->...->5->0.
  - Wrap 5->0 increments the frame counter.
  - Frame counter reaching BLINK_DIV-1 and wrapping toggles the blink phase.
- Outputs are registered with 1-cycle latency from the digit index. Input changes are picked up at the next output register update; the scan is never restarted by input changes.
- Page select:
  - clk_mode 3 with edit_field 3: weekday page. Digits 0-4 blank (an bit high); digit 5 shows weekday+1 (values 1..7).
  - clk_mode 3 otherwise: date page from date_bcd.
  - All other clk_mode values: time page from time_bcd.
  - clk_mode 2 shows time_bcd unchanged; the upstream formatter already muxes alarm time onto this bus.
- Nibble decode (active low):
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
  - Nibbles 0xA-0xF display a dash, 0x3F.
- Decimal points:
  - Time and date pages: dp low on digits 1 and 3.
  - Time page only: digit 5 dp = ~ampm.
  - Weekday page: dp high on all digits.
- Blink:
  - Applies only when clk_mode is 1 or 3.
  - While blink phase=1, both digits of the selected field (digits 2*edit_field and 2*edit_field+1) have their an bit forced high.
  - Weekday page: digit 5 blinks.
  - time page with edit_field=3: no blink.
- Edit restart:
  - Any change of edit_field or clk_mode clears the frame counter and blink phase next cycle, so the edited field is visible immediately.
  - This clear has priority over a blink toggle in the same cycle.
- Exactly one an bit is low at a time, except when a digit is blanked (then none).
- SCAN_DIV=1: the digit advances every cycle.
- Reset asserted mid-frame returns all outputs to the reset values on the next edge.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: on the time page, digit 0 with nibble 0 is blanked (an bit high). Date and weekday pages are unaffected.
- Undefined: digit 0 shows '0' (0x40) normally.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> an=3F, seg=7F, dp=1. Release, SCAN_DIV=2 -> first an=6'b111110 one cycle after release; an changes every 2 cycles.
- Time scan: clk_mode=0, time_bcd=24'h123456, ampm=1, SCAN_DIV=2 -> seg sequence 79,24,30,19,12,02 on an[0..5]; dp low on digits 1, 3, 5.
- Blink: SCAN_DIV=1, BLINK_DIV=2, clk_mode=1, edit_field=1 -> an[2],an[3] high for frames 2-3, low-capable for frames 0-1 and 4-5. Changing edit_field at frame 3 makes digits visible on the next frame.
- Weekday page: clk_mode=3, edit_field=3, weekday=2 -> digits 0-4 dark; digit 5 seg=0x30.
- Invalid BCD: time_bcd=24'hA00000 -> digit 0 seg=0x3F.
- Macro: time_bcd=24'h091500, clk_mode=0 -> digit 0 dark with LEADING_ZERO_BLANK_EN, seg=0x40 without; digit 1 seg=0x10 in both builds.
